// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO; the head entry is visible combinationally from registers.
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled, majority-voted 8N1 receiver feeding a byte FIFO with sticky
// framing-error and overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  output logic [7:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            frame_err,
  output logic                            overrun,
  input  logic                            err_clear,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  logic            rx_meta_q, rx_sync_q;
  logic            armed_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      smp_q, smp_d;
  logic            frame_err_q, overrun_q;
  logic            bit_val;
  logic            push;
  logic            frame_set;
  logic            fifo_full;
  logic            fifo_empty;
  logic            overrun_set;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign bit_val = majority3(smp_q[1], smp_q[0], rx_sync_q);

  // armed_q keeps a line held low through reset from looking like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      armed_q    <= 1'b0;
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      s_q        <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      smp_q      <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      if (rx_sync_q) armed_q <= 1'b1;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      state_q    <= state_d;
      s_q        <= s_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      smp_q      <= smp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    smp_d     = smp_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (tick) begin
      if (state_q == START || state_q == DATA || state_q == STOP) begin
        s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
        if (s_q == S_LO)  smp_d[0] = rx_sync_q;
        if (s_q == S_MID) smp_d[1] = rx_sync_q;
      end
      case (state_q)
        IDLE: begin
          if (!rx_sync_q && armed_q) begin
            state_d = START;
            s_d     = '0;
          end
        end
        START: begin
          if (s_q == S_HI && bit_val) begin
            state_d = IDLE;
            s_d     = '0;
          end else if (s_q == S_LAST) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (s_q == S_HI) shreg_d = {bit_val, shreg_q[7:1]};
          if (s_q == S_LAST) begin
            if (bit_idx_q == 3'd7) state_d = STOP;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is caught early.
          if (s_q == S_HI) begin
            s_d = '0;
            if (bit_val) begin
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_sync_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  uart_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .din_i   (shreg_q),
    .pop_i   (out_ready),
    .dout_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign overrun_set = push && fifo_full && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set   ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
      overrun_q   <= overrun_set ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
